coeff_dequantizer: RTL and testbench
====================================

# coeff_dequantizer

Streaming inverse quantizer for one transform block of quantized levels. It is the decoder-side counterpart of the forward quantization path. Per block it derives the transform shift from the channel/block configuration. It then scales each incoming level by the flat HEVC scale table and rounds, shifts and clips it into a reconstructed coefficient for the inverse transform.

## Interface
- COEFF_W, 23: output coefficient width; covers max dynamic range 22 plus sign.
- LEVEL_W, 16: signed input level width.
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  block configuration offered.
- cfg_ready  out  1  high only in IDLE.
- channel_bit_depth  in  4  sample bit depth.
- log2_tr_size  in  3  log2 block width; legal values 2..5.
- max_log2_tr_dynamic_range  in  5  15 normally, up to 22 with extended precision.
- use_transform_skip  in  1  block uses transform skip.
- extended_precision_processing  in  1  extended precision enabled.
- qp  in  6  quantization parameter, 0..51.
- lvl_valid / lvl_ready  in / out  1 / 1  level handshake.
- lvl_data  in  LEVEL_W  signed quantized level, raster order.
- coef_valid / coef_ready  out / in  1 / 1  coefficient handshake.
- coef_data  out  COEFF_W  signed dequantized coefficient.
- coef_last  out  1  marks the final coefficient of the block.
- busy  out  1  high in RUN or DRAIN.

## Operation
- Configuration capture on a cfg_valid && cfg_ready cycle:
  - log2_tr_size is clamped to 2..5.
  - qp is clamped to 51.
  - qp_per = qp/6 and qp_rem = qp%6.
  - tshift = max_dr − bit_depth − log2_size, as a signed 6-bit value.
  - If use_transform_skip && extended_precision_processing, tshift = max(0, tshift).
  - rshift = 6 − tshift − qp_per, as a signed 6-bit value.
  - count = 1 << (2·log2_size), i.e. 16, 64, 256 or 1024.
- Scale table by qp_rem: {40, 45, 51, 57, 64, 72}.
- Per-level result:
  - If rshift > 0: c = (level·scale + (1 << (rshift−1))) >>> rshift, arithmetic shift (floor).
  - If rshift ≤ 0: c = (level·scale) << −rshift.
  - The intermediate is at least 48 bits signed, so nothing overflows before the clip.
  - c is clipped to [−(1 << max_dr), (1 << max_dr) − 1].
- FSM:
  - IDLE: cfg_ready=1. A cfg handshake moves to RUN.
  - RUN: levels are accepted, and an accept counter increments per accepted level. Accepting level number count moves to DRAIN.
  - DRAIN: no levels are accepted. The output handshake that carries coef_last returns to IDLE.
- coef_last is asserted with the output derived from level number count.
- The pipeline advances when adv = !coef_valid || coef_ready.
  - lvl_ready = (state==RUN) && adv.
  - Output registers hold coef_data, coef_last and coef_valid stable while coef_valid && !coef_ready.
- Levels offered while not in RUN are ignored.
- Configuration inputs may change freely after capture.

## Timing
- Reset values: cfg_ready=0 during the rst cycle and 1 afterwards (IDLE). coef_valid=0, coef_data=0, coef_last=0, busy=0, lvl_ready=0, counter=0, pipeline valids cleared.
- Pipeline stages:
  - Stage 1 registers level·scale and the rounding offset.
  - Stage 2 registers the shifted, clipped coefficient.
- Latency: a level accepted at cycle t drives coef_valid at t+2 when there is no backpressure.
- Throughput is 1 coefficient per cycle. A 16-coefficient block with no stalls takes 1 config cycle + 16 accepts + 2 drain cycles.
- A new cfg handshake is possible in the cycle after the coef_last handshake. There is no block overlap.
- rst asserted mid-block discards all in-flight data. The block is back in IDLE on the next cycle and no coef_last is produced.
- A simultaneous final-level accept and coef_ready is legal and does not stall.

## Structure
- A shared package `dequant_pkg` holds:
  - the scale table constant and IQUANT_SHIFT = 6;
  - the FSM state enum {IDLE, RUN, DRAIN};
  - a config struct with the captured tshift, rshift, scale, max_dr and count.
- One sub-module, `dq_shift_derive`: the combinational tshift/rshift/qp split/count derivation, instantiated at config capture.

## Test plan
- Basic left-shift path: depth 8, size 2, max_dr 15, TS=0, EP=0, qp 22 (tshift 5, rshift −2, scale 64). Levels 3, −1, then 14 zeros → outputs 768, −256, then 0s. coef_last on the 16th output; busy drops after it.
- TS+EP clamp, right-shift rounding: depth 12, size 5, max_dr 15, TS=1, EP=1 (tshift 0), qp 4 (rshift 6). Levels 5, −5 → 5, −5. 1024 outputs total.
- TS without EP, no clamp: same as above but EP=0 (tshift −2, rshift 8), qp 4. Level 5 → 1 (448 >> 8).
- Saturation: depth 8, size 2, max_dr 15, qp 51 (rshift −7, scale 57). Levels 32767, −32768 → 32767, −32768.
- Backpressure: coef_ready held low 5 cycles mid-block → coef_data and coef_last stable, lvl_ready low, no loss or duplication. All 16 outputs in order.
- Reset mid-block: rst after 7 accepts → next cycle coef_valid=0 and cfg_ready=1. A following full block completes with correct values and exactly one coef_last.

Source files
------------

// File: rtl/dequant_pkg.sv
// Shared types and constants for the coefficient dequantizer.
// Latency: none (package only).
// Backpressure: n/a.
//
// Contents: HEVC flat scale table indexed by qp%6, the inverse-quantizer
// base shift, the block FSM states and the captured per-block config.
package dequant_pkg;

    localparam int IQUANT_SHIFT = 6;

    // Element [i] is the scale for qp%6 == i.
    localparam logic [5:0][6:0] SCALE_TABLE = {7'd72, 7'd64, 7'd57, 7'd51, 7'd45, 7'd40};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [5:0] tshift;
        logic signed [5:0] rshift;
        logic [6:0]        scale;
        logic [4:0]        max_dr;
        logic [10:0]       count;
    } dq_cfg_t;

    function automatic logic [6:0] scale_of(input logic [2:0] qp_rem);
        scale_of = SCALE_TABLE[0];
        for (int i = 0; i < 6; i++) begin
            if (qp_rem == 3'(i)) begin
                scale_of = SCALE_TABLE[i];
            end
        end
    endfunction

endpackage

// File: rtl/dq_shift_derive.sv
// Combinational per-block derivation of tshift, rshift, scale and coefficient count.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; sampled by the parent on its config handshake.
//
// Ports: raw block configuration in (bit depth, log2 size, max dynamic range,
// transform-skip / extended-precision flags, qp); cfg out as dq_cfg_t.
module dq_shift_derive
    import dequant_pkg::*;
(
    input  logic [3:0] channel_bit_depth,
    input  logic [2:0] log2_tr_size,
    input  logic [4:0] max_log2_tr_dynamic_range,
    input  logic       use_transform_skip,
    input  logic       extended_precision_processing,
    input  logic [5:0] qp,
    output dq_cfg_t    cfg
);

    logic [2:0] size_c;
    logic [5:0] qp_c;
    logic [3:0] qp_per;
    logic [2:0] qp_rem;
    logic [7:0] tshift_w;
    logic [5:0] tshift;
    logic [7:0] rshift_w;

    always_comb begin
        size_c = log2_tr_size;
        if (log2_tr_size < 3'd2) begin
            size_c = 3'd2;
        end else if (log2_tr_size > 3'd5) begin
            size_c = 3'd5;
        end

        qp_c   = (qp > 6'd51) ? 6'd51 : qp;
        qp_per = 4'(qp_c / 6'd6);
        qp_rem = 3'(qp_c % 6'd6);

        // Two's-complement arithmetic in 8 bits, then truncated to the
        // signed 6-bit field; the bit pattern is what matters.
        tshift_w = {3'b000, max_log2_tr_dynamic_range}
                 - {4'b0000, channel_bit_depth}
                 - {5'b00000, size_c};
        tshift   = tshift_w[5:0];
        if (use_transform_skip && extended_precision_processing && tshift[5]) begin
            tshift = '0;
        end

        rshift_w = 8'(IQUANT_SHIFT) - {{2{tshift[5]}}, tshift} - {4'b0000, qp_per};

        cfg.tshift = tshift;
        cfg.rshift = rshift_w[5:0];
        cfg.scale  = scale_of(qp_rem);
        cfg.max_dr = max_log2_tr_dynamic_range;
        cfg.count  = 11'd1 << {size_c, 1'b0};
    end

endmodule

// File: rtl/coeff_dequantizer.sv
// Streaming inverse quantizer: one transform block of levels -> clipped coefficients.
// Latency: 2 cycles from level accept to coef_valid; 1 coefficient per cycle.
// Backpressure: coef_ready low freezes both pipeline stages and drops lvl_ready.
//
// Ports: clk/rst (sync, active high); cfg_valid/cfg_ready plus block config;
// lvl_valid/lvl_ready/lvl_data input stream; coef_valid/coef_ready/coef_data/
// coef_last output stream; busy while a block is in flight.
module coeff_dequantizer
    import dequant_pkg::*;
#(
    parameter int COEFF_W = 23,
    parameter int LEVEL_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [3:0]                channel_bit_depth,
    input  logic [2:0]                log2_tr_size,
    input  logic [4:0]                max_log2_tr_dynamic_range,
    input  logic                      use_transform_skip,
    input  logic                      extended_precision_processing,
    input  logic [5:0]                qp,
    input  logic                      lvl_valid,
    output logic                      lvl_ready,
    input  logic signed [LEVEL_W-1:0] lvl_data,
    output logic                      coef_valid,
    input  logic                      coef_ready,
    output logic signed [COEFF_W-1:0] coef_data,
    output logic                      coef_last,
    output logic                      busy
);

    localparam int PROD_W = 48;
    localparam logic signed [PROD_W-1:0] ONE = PROD_W'(1);

    state_t  state, state_nxt;
    dq_cfg_t cfg_new, cfg_q;

    logic [10:0] acc_cnt;
    logic        adv, cfg_fire, lvl_fire, out_fire, last_accept;

    logic                     s1_vld, s1_last;
    logic signed [PROD_W-1:0] s1_prod, s1_off;

    logic signed [PROD_W-1:0] lvl_ext, scl_ext, prod_w, off_w;
    logic signed [PROD_W-1:0] sum_w, shifted_w, pow, clip_hi, clip_lo, coef_sat;
    logic                     rs_pos;
    logic [5:0]               lsh;
    logic [COEFF_W-1:0]       coef_nxt;

    dq_shift_derive u_derive (
        .channel_bit_depth             (channel_bit_depth),
        .log2_tr_size                  (log2_tr_size),
        .max_log2_tr_dynamic_range     (max_log2_tr_dynamic_range),
        .use_transform_skip            (use_transform_skip),
        .extended_precision_processing (extended_precision_processing),
        .qp                            (qp),
        .cfg                           (cfg_new)
    );

    // Handshakes. rst gating keeps the ready outputs low during the reset cycle.
    assign adv         = !coef_valid || coef_ready;
    assign cfg_ready   = (state == IDLE) && !rst;
    assign lvl_ready   = (state == RUN) && adv && !rst;
    assign cfg_fire    = cfg_valid && cfg_ready;
    assign lvl_fire    = lvl_valid && lvl_ready;
    assign out_fire    = coef_valid && coef_ready;
    assign last_accept = lvl_fire && (acc_cnt == cfg_q.count - 11'd1);
    assign busy        = (state == RUN) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_fire) state_nxt = RUN;
            RUN:     if (last_accept) state_nxt = DRAIN;
            DRAIN:   if (out_fire && coef_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1 operands: product and rounding offset (offset only for right shifts).
    always_comb begin
        lvl_ext = {{(PROD_W-LEVEL_W){lvl_data[LEVEL_W-1]}}, lvl_data};
        scl_ext = {{(PROD_W-7){1'b0}}, cfg_q.scale};
        prod_w  = lvl_ext * scl_ext;
        rs_pos  = !cfg_q.rshift[5] && (cfg_q.rshift != 6'sd0);
        off_w   = '0;
        if (rs_pos) begin
            off_w = ONE << 6'(cfg_q.rshift - 6'sd1);
        end
    end

    // Stage 2 operands: shift (floor on the right), then clip to the dynamic range.
    always_comb begin
        sum_w = s1_prod + s1_off;
        lsh   = 6'(~cfg_q.rshift) + 6'd1;
        if (rs_pos) begin
            shifted_w = sum_w >>> cfg_q.rshift;
        end else begin
            shifted_w = sum_w <<< lsh;
        end
        pow      = ONE << cfg_q.max_dr;
        clip_hi  = pow - ONE;
        clip_lo  = -pow;
        coef_sat = shifted_w;
        if (shifted_w > clip_hi) begin
            coef_sat = clip_hi;
        end else if (shifted_w < clip_lo) begin
            coef_sat = clip_lo;
        end
        coef_nxt = coef_sat[COEFF_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q      <= '0;
            acc_cnt    <= '0;
            s1_vld     <= 1'b0;
            s1_last    <= 1'b0;
            s1_prod    <= '0;
            s1_off     <= '0;
            coef_valid <= 1'b0;
            coef_data  <= '0;
            coef_last  <= 1'b0;
        end else begin
            if (cfg_fire) begin
                cfg_q   <= cfg_new;
                acc_cnt <= '0;
            end else if (lvl_fire) begin
                acc_cnt <= acc_cnt + 11'd1;
            end

            // Whole pipeline moves together; a stalled output freezes both stages.
            if (adv) begin
                s1_vld     <= lvl_fire;
                s1_last    <= last_accept;
                coef_valid <= s1_vld;
                coef_last  <= s1_vld && s1_last;
                if (lvl_fire) begin
                    s1_prod <= prod_w;
                    s1_off  <= off_w;
                end
                if (s1_vld) begin
                    coef_data <= coef_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_coeff_dequantizer.sv
// Directed self-checking bench for coeff_dequantizer.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_coeff_dequantizer;

    localparam int COEFF_W = 23;
    localparam int LEVEL_W = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [3:0]                channel_bit_depth;
    logic [2:0]                log2_tr_size;
    logic [4:0]                max_log2_tr_dynamic_range;
    logic                      use_transform_skip;
    logic                      extended_precision_processing;
    logic [5:0]                qp;
    logic                      lvl_valid;
    logic                      lvl_ready;
    logic signed [LEVEL_W-1:0] lvl_data;
    logic                      coef_valid;
    logic                      coef_ready;
    logic signed [COEFF_W-1:0] coef_data;
    logic                      coef_last;
    logic                      busy;

    int checks = 0;
    int errors = 0;
    int lv[1024];
    int ex[1024];

    always #5 clk = ~clk;

    coeff_dequantizer #(.COEFF_W(COEFF_W), .LEVEL_W(LEVEL_W)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .cfg_valid                     (cfg_valid),
        .cfg_ready                     (cfg_ready),
        .channel_bit_depth             (channel_bit_depth),
        .log2_tr_size                  (log2_tr_size),
        .max_log2_tr_dynamic_range     (max_log2_tr_dynamic_range),
        .use_transform_skip            (use_transform_skip),
        .extended_precision_processing (extended_precision_processing),
        .qp                            (qp),
        .lvl_valid                     (lvl_valid),
        .lvl_ready                     (lvl_ready),
        .lvl_data                      (lvl_data),
        .coef_valid                    (coef_valid),
        .coef_ready                    (coef_ready),
        .coef_data                     (coef_data),
        .coef_last                     (coef_last),
        .busy                          (busy)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_vectors();
        for (int i = 0; i < 1024; i++) begin
            lv[i] = 0;
            ex[i] = 0;
        end
    endtask

    // One cfg handshake; returns at the falling edge after it, config scrambled.
    task automatic do_cfg(input string tag, input logic [3:0] bd, input logic [2:0] sz,
                          input logic [4:0] mdr, input logic ts, input logic ep, input logic [5:0] q);
        @(negedge clk);
        channel_bit_depth             = bd;
        log2_tr_size                  = sz;
        max_log2_tr_dynamic_range     = mdr;
        use_transform_skip            = ts;
        extended_precision_processing = ep;
        qp                            = q;
        cfg_valid                     = 1'b1;
        #1;
        chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
        @(negedge clk);
        cfg_valid                     = 1'b0;
        channel_bit_depth             = 4'($urandom);
        log2_tr_size                  = 3'($urandom);
        max_log2_tr_dynamic_range     = 5'($urandom);
        use_transform_skip            = 1'($urandom);
        extended_precision_processing = 1'($urandom);
        qp                            = 6'($urandom);
    endtask

    task automatic run_block(input string tag, input logic [3:0] bd, input logic [2:0] sz,
                             input logic [4:0] mdr, input logic ts, input logic ep, input logic [5:0] q,
                             input int n, input int stall_at, input int stall_len, input bit chk_lat);
        int li;
        int oi;
        int cyc;
        int acc_cyc;
        do_cfg(tag, bd, sz, mdr, ts, ep, q);
        #1;
        chk({tag, "_busy_run"}, 64'(busy), 64'd1);
        li      = 0;
        oi      = 0;
        cyc     = 0;
        acc_cyc = 0;
        while (oi < n && cyc < n + 100) begin
            coef_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            lvl_valid  = (li < n);
            lvl_data   = LEVEL_W'(lv[(li < n) ? li : 0]);
            #1;
            if (coef_valid) begin
                if (chk_lat && oi == 0) begin
                    chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd2);
                end
                if (coef_ready) begin
                    chk($sformatf("%s_data[%0d]", tag, oi), 64'($signed(coef_data)), 64'(ex[oi]));
                    chk($sformatf("%s_last[%0d]", tag, oi), 64'(coef_last), 64'(oi == n - 1));
                    oi++;
                end else begin
                    chk($sformatf("%s_hold_data[%0d]", tag, oi), 64'($signed(coef_data)), 64'(ex[oi]));
                    chk($sformatf("%s_hold_last[%0d]", tag, oi), 64'(coef_last), 64'(oi == n - 1));
                    chk({tag, "_hold_lvl_ready"}, 64'(lvl_ready), 64'd0);
                end
            end
            if (lvl_valid && lvl_ready) begin
                if (li == 0) acc_cyc = cyc;
                li++;
            end
            cyc++;
            @(negedge clk);
        end
        lvl_valid  = 1'b0;
        coef_ready = 1'b1;
        #1;
        chk({tag, "_out_count"}, 64'(oi), 64'(n));
        chk({tag, "_in_count"}, 64'(li), 64'(n));
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_cfg_ready_after"}, 64'(cfg_ready), 64'd1);
        chk({tag, "_no_extra_out"}, 64'(coef_valid), 64'd0);
    endtask

    initial begin
        int accepted;
        rst                           = 1'b1;
        cfg_valid                     = 1'b0;
        channel_bit_depth             = '0;
        log2_tr_size                  = '0;
        max_log2_tr_dynamic_range     = '0;
        use_transform_skip            = 1'b0;
        extended_precision_processing = 1'b0;
        qp                            = '0;
        lvl_valid                     = 1'b0;
        lvl_data                      = '0;
        coef_ready                    = 1'b1;

        // Reset state (one rising edge has passed with rst high).
        @(negedge clk);
        #1;
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst_coef_valid", 64'(coef_valid), 64'd0);
        chk("rst_coef_data", 64'($signed(coef_data)), 64'd0);
        chk("rst_coef_last", 64'(coef_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_lvl_ready", 64'(lvl_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_cfg_ready", 64'(cfg_ready), 64'd1);

        // Left-shift path: tshift 5, rshift -2, scale 64.
        clear_vectors();
        lv[0] = 3;  ex[0] = 768;
        lv[1] = -1; ex[1] = -256;
        run_block("basic", 4'd8, 3'd2, 5'd15, 1'b0, 1'b0, 6'd22, 16, 1000, 0, 1'b1);

        // TS+EP clamps tshift to 0, rshift 6 with rounding.
        clear_vectors();
        lv[0] = 5;  ex[0] = 5;
        lv[1] = -5; ex[1] = -5;
        run_block("tsep", 4'd12, 3'd5, 5'd15, 1'b1, 1'b1, 6'd4, 1024, 5000, 0, 1'b0);

        // TS without EP: tshift -2 kept, rshift 8.
        clear_vectors();
        lv[0] = 5;   ex[0] = 1;
        lv[1] = -5;  ex[1] = -1;
        lv[2] = 384; ex[2] = 96;
        run_block("ts", 4'd12, 3'd5, 5'd15, 1'b1, 1'b0, 6'd4, 1024, 5000, 0, 1'b0);

        // Saturation; qp 63 clamps to 51 -> scale 57, rshift -7.
        clear_vectors();
        lv[0] = 32767;  ex[0] = 32767;
        lv[1] = -32768; ex[1] = -32768;
        lv[2] = 1;      ex[2] = 7296;
        lv[3] = -1;     ex[3] = -7296;
        lv[4] = 4;      ex[4] = 29184;
        lv[5] = 5;      ex[5] = 32767;
        run_block("sat", 4'd8, 3'd2, 5'd15, 1'b0, 1'b0, 6'd63, 16, 1000, 0, 1'b0);

        // Backpressure: 5 stalled cycles mid-block, distinct values for order.
        clear_vectors();
        for (int k = 0; k < 16; k++) begin
            lv[k] = k + 1;
            ex[k] = 256 * (k + 1);
        end
        run_block("bp", 4'd8, 3'd2, 5'd15, 1'b0, 1'b0, 6'd22, 16, 6, 5, 1'b0);

        // Levels offered in IDLE are ignored.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            lvl_valid = 1'b1;
            lvl_data  = 16'sd77;
            #1;
            chk("idle_lvl_ready", 64'(lvl_ready), 64'd0);
            chk("idle_coef_valid", 64'(coef_valid), 64'd0);
        end
        @(negedge clk);
        lvl_valid = 1'b0;

        // Reset after 7 accepts discards the block.
        do_cfg("mid", 4'd8, 3'd2, 5'd15, 1'b0, 1'b0, 6'd22);
        accepted = 0;
        for (int c = 0; c < 40 && accepted < 7; c++) begin
            lvl_valid = 1'b1;
            lvl_data  = 16'sd9;
            #1;
            if (lvl_ready) accepted++;
            @(negedge clk);
        end
        chk("mid_accepted", 64'(accepted), 64'd7);
        lvl_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_coef_valid", 64'(coef_valid), 64'd0);
        chk("mid_rst_coef_last", 64'(coef_last), 64'd0);
        chk("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);

        // Full block after reset; log2 size 0 clamps to 2, rshift 1, scale 40.
        clear_vectors();
        lv[0] = 7;  ex[0] = 140;
        lv[1] = -3; ex[1] = -60;
        run_block("post", 4'd8, 3'd0, 5'd15, 1'b0, 1'b0, 6'd0, 16, 1000, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
